text_console_writer: RTL and testbench

- Converts an 8-bit character stream into write cycles for the 80x30 text-mode character buffer.
- The HDMI text renderer reads the same buffer: one byte per cell, address = row*COLS + col, blank = 0x20.
- Maintains a cursor and interprets a small set of control codes.
- Handles line wrap, new-line clearing and full-screen clear, so firmware or a UART can treat the display as a dumb terminal.

---
 rtl/text_console_writer_if.sv | 25 ++
 rtl/text_console_writer.sv | 132 +++++++++++++
 tb/tb_text_console_writer.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/text_console_writer_if.sv
// Character-stream input and text-buffer write port of the console writer.
// master = byte source / buffer sink, slave = the writer itself.
interface text_console_writer_if #(
    parameter int ADDR_W = 12
);
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic [6:0]        cursor_x;
    logic [4:0]        cursor_y;
    logic              busy;

    modport master (
        output in_data, in_valid,
        input  in_ready, wr_en, wr_addr, wr_data, cursor_x, cursor_y, busy
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, wr_en, wr_addr, wr_data, cursor_x, cursor_y, busy
    );
endinterface

// File: rtl/text_console_writer.sv
// Dumb-terminal front end: turns a byte stream into text-buffer writes,
// tracking a cursor and running full-screen / single-line clear sequences.
module text_console_writer #(
    parameter int         COLS   = 80,
    parameter int         ROWS   = 30,
    parameter int         ADDR_W = 12,
    parameter logic [7:0] FILL   = 8'h20
) (
    input  logic                 clk_25mhz,
    input  logic                 resetn,
    text_console_writer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CLR_SCREEN, CLR_LINE} state_t;

    localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(COLS*ROWS - 1);
    localparam logic [ADDR_W-1:0] LAST_K    = ADDR_W'(COLS - 1);
    localparam logic [ADDR_W-1:0] COLS_A    = ADDR_W'(COLS);

    state_t            state_q;
    logic [ADDR_W-1:0] cnt_q;
    logic [ADDR_W-1:0] base_q;
    logic [6:0]        cx_q;
    logic [4:0]        cy_q;
    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [7:0]        wr_data_q;

    logic [ADDR_W-1:0] cur_addr;
    logic [ADDR_W-1:0] nxt_base;
    logic [4:0]        nxt_row;
    logic              accept;
    logic              printable;

    assign cur_addr  = ADDR_W'(cy_q) * COLS_A + ADDR_W'(cx_q);
    assign nxt_row   = (cy_q == 5'(ROWS - 1)) ? 5'd0 : cy_q + 5'd1;
    assign nxt_base  = ADDR_W'(nxt_row) * COLS_A;
    assign accept    = (state_q == IDLE) && bus.in_valid;
    assign printable = (bus.in_data >= 8'h20) && (bus.in_data <= 8'h7E);

    always_ff @(posedge clk_25mhz or negedge resetn) begin
        if (!resetn) begin
            state_q   <= CLR_SCREEN;
            cnt_q     <= '0;
            base_q    <= '0;
            cx_q      <= '0;
            cy_q      <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= FILL;
        end else begin
            wr_en_q <= 1'b0;
            case (state_q)
                CLR_SCREEN: begin
                    wr_en_q   <= 1'b1;
                    wr_addr_q <= cnt_q;
                    wr_data_q <= FILL;
                    if (cnt_q == LAST_CELL) begin
                        cnt_q   <= '0;
                        cx_q    <= '0;
                        cy_q    <= '0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + ADDR_W'(1);
                    end
                end
                CLR_LINE: begin
                    // base_q already holds the new row's first cell
                    wr_en_q   <= 1'b1;
                    wr_addr_q <= base_q + cnt_q;
                    wr_data_q <= FILL;
                    if (cnt_q == LAST_K) begin
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + ADDR_W'(1);
                    end
                end
                default: begin
                    if (accept) begin
                        if (printable) begin
                            wr_en_q   <= 1'b1;
                            wr_addr_q <= cur_addr;
                            wr_data_q <= bus.in_data;
                            if (cx_q == 7'(COLS - 1)) begin
                                cx_q    <= '0;
                                cy_q    <= nxt_row;
                                base_q  <= nxt_base;
                                cnt_q   <= '0;
                                state_q <= CLR_LINE;
                            end else begin
                                cx_q <= cx_q + 7'd1;
                            end
                        end else begin
                            case (bus.in_data)
                                8'h0D: cx_q <= '0;
                                8'h0A: begin
                                    cx_q    <= '0;
                                    cy_q    <= nxt_row;
                                    base_q  <= nxt_base;
                                    cnt_q   <= '0;
                                    state_q <= CLR_LINE;
                                end
                                8'h08: begin
                                    // no reverse wrap: BS at column 0 is a no-op
                                    if (cx_q != 7'd0) begin
                                        cx_q      <= cx_q - 7'd1;
                                        wr_en_q   <= 1'b1;
                                        wr_addr_q <= cur_addr - ADDR_W'(1);
                                        wr_data_q <= FILL;
                                    end
                                end
                                8'h0C: begin
                                    cnt_q   <= '0;
                                    state_q <= CLR_SCREEN;
                                end
                                default: ;
                            endcase
                        end
                    end
                end
            endcase
        end
    end

    assign bus.in_ready = (state_q == IDLE);
    assign bus.busy     = (state_q != IDLE);
    assign bus.wr_en    = wr_en_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = wr_data_q;
    assign bus.cursor_x = cx_q;
    assign bus.cursor_y = cy_q;
endmodule

// File: tb/tb_text_console_writer.sv
// Scoreboard bench for text_console_writer: stimulus queues expected buffer
// writes, a negedge monitor pops and compares each write the DUT emits.
module tb_text_console_writer;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #20 clk = ~clk;

    text_console_writer_if #(.ADDR_W(12)) bus ();

    text_console_writer #(.COLS(80), .ROWS(30), .ADDR_W(12), .FILL(8'h20)) dut (
        .clk_25mhz(clk),
        .resetn   (resetn),
        .bus      (bus)
    );

    int total = 0;
    int bad   = 0;
    logic [19:0] sb[$];
    logic [19:0] exp_w;
    int mx = 0;
    int my = 0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        total++;
        bad++;
        $display("FAIL %s: timed out", nm);
    endtask

    always @(negedge clk) begin
        if (resetn && bus.wr_en) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected write: addr=%0d data=%02h, none expected",
                         bus.wr_addr, bus.wr_data);
            end else begin
                exp_w = sb.pop_front();
                if ({bus.wr_addr, bus.wr_data} !== exp_w) begin
                    bad++;
                    $display("FAIL write: got addr=%0d data=%02h expected addr=%0d data=%02h",
                             bus.wr_addr, bus.wr_data, exp_w[19:8], exp_w[7:0]);
                end
            end
        end
    end

    task automatic push(input int a, input logic [7:0] d);
        sb.push_back({12'(a), d});
    endtask

    task automatic push_line(input int r);
        for (int k = 0; k < 80; k++) push(r * 80 + k, 8'h20);
    endtask

    task automatic push_screen();
        for (int k = 0; k < 2400; k++) push(k, 8'h20);
        mx = 0;
        my = 0;
    endtask

    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) timeout("in_ready wait");
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        if (b >= 8'h20 && b <= 8'h7E) begin
            push(my * 80 + mx, b);
            if (mx < 79) mx++;
            else begin
                mx = 0;
                my = (my + 1) % 30;
                push_line(my);
            end
        end else if (b == 8'h0D) begin
            mx = 0;
        end else if (b == 8'h0A) begin
            mx = 0;
            my = (my + 1) % 30;
            push_line(my);
        end else if (b == 8'h08) begin
            if (mx > 0) begin
                mx--;
                push(my * 80 + mx, 8'h20);
            end
        end else if (b == 8'h0C) begin
            push_screen();
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) timeout("scoreboard drain");
        repeat (3) @(negedge clk);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " wr_en"},    int'(bus.wr_en), 0);
        chk({tag, " wr_addr"},  int'(bus.wr_addr), 0);
        chk({tag, " wr_data"},  int'(bus.wr_data), 32);
        chk({tag, " cursor_x"}, int'(bus.cursor_x), 0);
        chk({tag, " cursor_y"}, int'(bus.cursor_y), 0);
        chk({tag, " in_ready"}, int'(bus.in_ready), 0);
        chk({tag, " busy"},     int'(bus.busy), 1);
    endtask

    task automatic chk_cur(input string tag, input int x, input int y);
        chk({tag, " cursor_x"}, int'(bus.cursor_x), x);
        chk({tag, " cursor_y"}, int'(bus.cursor_y), y);
    endtask

    task automatic release_and_time(input string tag);
        int n;
        n = 0;
        @(negedge clk) resetn = 1'b1;
        do begin
            @(posedge clk);
            n++;
            #1;
        end while (!bus.in_ready && n < 3000);
        chk({tag, " clear cycles"}, n, 2400);
        drain();
        chk({tag, " in_ready"}, int'(bus.in_ready), 1);
        chk({tag, " busy"}, int'(bus.busy), 0);
        chk_cur(tag, 0, 0);
    endtask

    initial begin
        int n;
        bus.in_data  = 8'h00;
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset("por");
        push_screen();
        release_and_time("power-up");

        send(8'h41); send(8'h42); send(8'h43);
        drain();
        chk_cur("ABC", 3, 0);

        send(8'h0D);
        for (int i = 0; i < 79; i++) send(8'h61 + 8'(i % 26));
        send(8'h5A);
        chk_cur("wrap", 0, 1);
        chk("wrap in_ready", int'(bus.in_ready), 0);
        drain();
        chk("after line clear in_ready", int'(bus.in_ready), 1);

        repeat (28) send(8'h0A);
        for (int i = 0; i < 5; i++) send(8'h30 + 8'(i));
        drain();
        chk_cur("row29", 5, 29);
        send(8'h0A);
        chk_cur("LF wrap", 0, 0);
        drain();
        send(8'h51);
        drain();
        chk_cur("Q", 1, 0);

        send(8'h0A); send(8'h0A);
        send(8'h78); send(8'h79); send(8'h7A);
        drain();
        chk_cur("pre-BS", 3, 2);
        send(8'h08);
        drain();
        chk_cur("BS", 2, 2);
        send(8'h0D);
        send(8'h08);
        drain();
        chk_cur("BS col0", 0, 2);
        send(8'h07); send(8'hFF);
        drain();
        chk_cur("discard", 0, 2);
        chk("discard in_ready", int'(bus.in_ready), 1);

        send(8'h0C);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(bus.wr_en && bus.wr_addr == 12'd1000) && n < 3000);
        if (!(bus.wr_en && bus.wr_addr == 12'd1000)) timeout("clear reaching 1000");
        #2 resetn = 1'b0;
        #1 chk_reset("mid-clear");
        sb.delete();
        push_screen();
        release_and_time("restart");

        repeat (5) @(negedge clk);
        chk("scoreboard empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
